pll_phase_ctl: RTL and testbench
================================

Name: pll_phase_ctl

Overview:
- Parametrised successor to the fixed single-output ECP5 PLL wrapper.
- Sequences EHXPLLL dynamic phase-shift pins (PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG) on request, for up to 4 output channels, with programmable timing.
- Qualifies the PLL lock signal and generates the downstream system reset (rst_out). Counts lock-loss events.
- Runs in the PLL reference-clock domain; sits beside the PLL instance in the clock block.

Parameters:
- NCH, 4, number of phase-steppable PLL outputs (1..4).
- STEPW, 8, width of step-count field.
- SETUP_CYC, 4, cycles sel/dir are stable before first step pulse, and settle cycles after load.
- PULSE_CYC, 4, high time and low time of each phasestep / phaseloadreg pulse (>=1).
- LOCK_CYC, 1024, consecutive synchronised-locked cycles required before rst_out deasserts (>=2).

Ports:
- clk  in  1  reference clock (PLL CLKI domain)
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL LOCK, asynchronous to clk
- req_valid  in  1  phase-shift request
- req_ready  out  1  request accepted when valid&ready
- req_ch  in  2  target output (PHASESEL encoding)
- req_dir  in  1  passed to PHASEDIR
- req_steps  in  STEPW  number of phase steps
- phasesel  out  2  to EHXPLLL PHASESEL[1:0]
- phasedir  out  1  to PHASEDIR
- phasestep  out  1  to PHASESTEP
- phaseloadreg  out  1  to PHASELOADREG
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: rejected request
- rst_out  out  1  system reset, high until lock qualified
- lock_lost_cnt  out  8  saturating lock-loss count

Behaviour:
- Reset values (asserted asynchronously, immediately on rst): phasesel=0, phasedir=0, phasestep=0, phaseloadreg=0, busy=0, done=0, err=0, req_ready=0, rst_out=1, lock_lost_cnt=0, FSM=IDLE, lock counter=0.
- Reset mid-sequence aborts it. Pulses drop at once; no resume.
- Lock qualification:
  - pll_locked passes through a 2-FF synchroniser (lk).
  - Counter increments while lk=1 and saturates at LOCK_CYC. It clears on any lk=0.
  - lock_ok = (counter==LOCK_CYC). rst_out = !lock_ok, registered.
  - lk falling while lock_ok=1: lock_lost_cnt += 1, saturating at 255. rst_out rises the next cycle.
- req_ready = (state==IDLE) & lock_ok.
- Accept rules:
  - req_ch >= NCH: no sequence; err pulses next cycle.
  - req_steps==0: no pin activity; done pulses next cycle.
- Otherwise the FSM runs, with cnt as the phase timer and rem as remaining steps:
  - IDLE -> SETUP: latch ch/dir/steps; drive phasesel/phasedir; busy=1.
  - SETUP: hold SETUP_CYC cycles -> STEP_HI.
  - STEP_HI: phasestep=1 for PULSE_CYC cycles -> STEP_LO.
  - STEP_LO: phasestep=0 for PULSE_CYC cycles; rem -= 1. If rem!=0 -> STEP_HI, else -> LOAD.
  - LOAD: phaseloadreg=1 for PULSE_CYC cycles -> SETTLE.
  - SETTLE: phaseloadreg=0 for SETUP_CYC cycles -> IDLE. Pulse done; busy=0 on the same cycle.
- phasesel/phasedir hold their last values in IDLE; they change only on accept.
- Timing: accept at cycle T, busy from T+1. done at T+1 + SETUP_CYC + 2·PULSE_CYC·N + PULSE_CYC + SETUP_CYC.
- Lock loss mid-sequence: the sequence completes normally; rst_out still asserts. New requests stall until relock.
- All outputs are registered, so there are no glitches on PLL control pins.
- Timer width = clog2(max(SETUP_CYC,PULSE_CYC)+1). Lock counter width = clog2(LOCK_CYC+1).

Decomposition:
- Shared package clk_pkg holds:
  - FSM state enum (IDLE, SETUP, STEP_HI, STEP_LO, LOAD, SETTLE)
  - PHASESEL channel constants (CLKOP=0, CLKOS=1, CLKOS2=2, CLKOS3=3)
- One sub-module: pll_lock_qual. It contains the synchroniser, lock counter, rst_out and lock_lost_cnt, and is reusable by other clock blocks.

Test Plan:
All cases use SETUP_CYC=2, PULSE_CYC=2, LOCK_CYC=16.
- Reset/lock: rst pulse, pll_locked=1 from cycle 0 -> rst_out=1 until 18 cycles after rst release (2 sync + 16), then 0. req_ready rises with it.
- Single channel: req ch=1, dir=1, steps=3 -> phasesel=1, phasedir=1 from T+1. Exactly 3 phasestep pulses, 2 high/2 low. Then one 2-cycle phaseloadreg. done at T+19; busy low same cycle.
- Edge requests: steps=0 -> done at T+1, no pin toggles. ch=3 with NCH=2 -> err at T+1, pins unchanged, busy stays 0.
- Lock loss: drop pll_locked 5 cycles during a steps=2 sequence -> sequence completes. rst_out high from 3 cycles after drop. lock_lost_cnt=1. req_ready low until 16 qualified cycles after reassert.
- Glitch filter: pll_locked low for 1 cycle every 10 cycles -> lock_ok never reached, rst_out stays 1. 300 lock losses after qualification -> lock_lost_cnt saturates at 255.
- Async reset mid-STEP_HI -> phasestep=0, busy=0, rst_out=1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/clk_pkg.sv
// clk_pkg: shared clock-block types, PHASESEL channel codes and helpers.
package clk_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STEP_HI, STEP_LO, LOAD, SETTLE} state_t;
  localparam logic [1:0] CLKOP  = 2'd0;
  localparam logic [1:0] CLKOS  = 2'd1;
  localparam logic [1:0] CLKOS2 = 2'd2;
  localparam logic [1:0] CLKOS3 = 2'd3;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pll_lock_qual.sv
// pll_lock_qual: synchronises PLL LOCK, qualifies it over LOCK_CYC cycles,
// drives the downstream reset and counts lock losses.
module pll_lock_qual
  import clk_pkg::*;
#(
  parameter int LOCK_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       rst_out,
  output logic       lock_ok,
  output logic [7:0] lock_lost_cnt
);
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_CYC);
  logic          s1_q, lk_q;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          rst_out_q, rst_out_d;
  logic [7:0]    lost_q, lost_d;
  logic          qual;
  assign qual = cnt_q == LMAX;
  // s1_q is the value lk takes at this edge, so the counter follows lk directly
  always_comb begin
    cnt_d     = !s1_q ? '0 : (qual ? cnt_q : cnt_q + 1'b1);
    rst_out_d = !qual;
    lost_d    = (lk_q && !s1_q && qual && lost_q != 8'hff) ? lost_q + 8'd1 : lost_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q      <= 1'b0;
      lk_q      <= 1'b0;
      cnt_q     <= '0;
      rst_out_q <= 1'b1;
      lost_q    <= '0;
    end else begin
      s1_q      <= pll_locked;
      lk_q      <= s1_q;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      lost_q    <= lost_d;
    end
  assign rst_out       = rst_out_q;
  assign lock_ok       = !rst_out_q;
  assign lock_lost_cnt = lost_q;
endmodule

// File: rtl/pll_phase_ctl.sv
// pll_phase_ctl: sequences ECP5 EHXPLLL dynamic phase-shift pins on request
// and qualifies PLL lock for the downstream system reset.
module pll_phase_ctl
  import clk_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int STEPW     = 8,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 4,
  parameter int LOCK_CYC  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_ch,
  input  logic             req_dir,
  input  logic [STEPW-1:0] req_steps,
  output logic [1:0]       phasesel,
  output logic             phasedir,
  output logic             phasestep,
  output logic             phaseloadreg,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rst_out,
  output logic [7:0]       lock_lost_cnt
);
  localparam int TW = $clog2(imax(SETUP_CYC, PULSE_CYC) + 1);
  localparam logic [TW-1:0] S_END = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] P_END = TW'(PULSE_CYC - 1);
  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic [1:0]       phasesel_q, phasesel_d;
  logic             phasedir_q, phasedir_d;
  logic             phasestep_q, phasestep_d;
  logic             phaseloadreg_q, phaseloadreg_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             lock_ok, accept, bad_ch, start, last;
  pll_lock_qual #(.LOCK_CYC(LOCK_CYC)) u_lock (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .rst_out      (rst_out),
    .lock_ok      (lock_ok),
    .lock_lost_cnt(lock_lost_cnt)
  );
  assign req_ready = state_q == IDLE && lock_ok;
  assign accept    = req_valid && req_ready;
  assign bad_ch    = 32'(req_ch) >= NCH;
  assign start     = accept && !bad_ch && req_steps != '0;
  assign last      = cnt_q == ((state_q == SETUP || state_q == SETTLE) ? S_END : P_END);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rem_q          <= '0;
      phasesel_q     <= '0;
      phasedir_q     <= 1'b0;
      phasestep_q    <= 1'b0;
      phaseloadreg_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      phasesel_q     <= phasesel_d;
      phasedir_q     <= phasedir_d;
      phasestep_q    <= phasestep_d;
      phaseloadreg_q <= phaseloadreg_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE:    if (start) begin
                 state_d = SETUP;
                 rem_d   = req_steps;
               end
      SETUP:   if (last) state_d = STEP_HI;
      STEP_HI: if (last) state_d = STEP_LO;
      STEP_LO: if (last) begin
                 rem_d   = rem_q - 1'b1;
                 state_d = rem_q == STEPW'(1) ? LOAD : STEP_HI;
               end
      LOAD:    if (last) state_d = SETTLE;
      SETTLE:  if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // pin outputs are registered images of the next state
  always_comb begin
    phasesel_d     = start ? req_ch : phasesel_q;
    phasedir_d     = start ? req_dir : phasedir_q;
    phasestep_d    = state_d == STEP_HI;
    phaseloadreg_d = state_d == LOAD;
    busy_d         = state_d != IDLE;
    done_d         = (state_q == SETTLE && state_d == IDLE) || (accept && !bad_ch && req_steps == '0);
    err_d          = accept && bad_ch;
  end
  assign phasesel     = phasesel_q;
  assign phasedir     = phasedir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = phaseloadreg_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
endmodule

// File: tb/tb_pll_phase_ctl.sv
// tb_pll_phase_ctl: directed stimulus with a done/err scoreboard for pll_phase_ctl.
module tb_pll_phase_ctl;
  logic       clk = 1'b0, rst = 1'b1, pll_locked = 1'b1, req_valid = 1'b0, req_dir = 1'b0;
  logic [1:0] req_ch = '0;
  logic [7:0] req_steps = '0;
  logic       req_ready, phasedir, phasestep, phaseloadreg, busy, done, err, rst_out;
  logic [1:0] phasesel;
  logic [7:0] lock_lost_cnt;
  int         cyc = 0, checks = 0, errors = 0;
  typedef struct {bit is_err; int at;} exp_t;
  exp_t exp_q[$];

  pll_phase_ctl #(.NCH(2), .STEPW(8), .SETUP_CYC(2), .PULSE_CYC(2), .LOCK_CYC(16)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_dir(req_dir), .req_steps(req_steps), .phasesel(phasesel),
    .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg), .busy(busy),
    .done(done), .err(err), .rst_out(rst_out), .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // called at a negedge; the request is presented in cycle t, accepted at the next edge
  task automatic req(input logic [1:0] ch, input logic dir, input logic [7:0] st,
                     input bit is_err, input int lat, output int t);
    exp_t e;
    chk("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_ch = ch; req_dir = dir; req_steps = st;
    t = cyc;
    e.is_err = is_err; e.at = t + lat;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  always @(negedge clk)
    if (!rst && (done || err)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: done=%0d err=%0d with nothing expected (cycle %0d)", done, err, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_kind_err", err, e.is_err);
        chk("out_kind_done", done, !e.is_err);
        chk("out_cycle", cyc, e.at);
      end
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, w;
    logic [18:0] ps, lr, bz;
    bit seen_low, any;
    repeat (3) @(negedge clk);
    chk("reset_rst_out", rst_out, 1);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_phasestep", phasestep, 0);
    chk("reset_phasesel", phasesel, 0);
    chk("reset_lost", lock_lost_cnt, 0);
    rst = 1'b0;
    repeat (17) @(negedge clk);
    chk("lock_rst_out_at17", rst_out, 1);
    @(negedge clk);
    chk("lock_rst_out_at18", rst_out, 0);
    chk("lock_req_ready_at18", req_ready, 1);

    // single channel, 3 steps: SETUP 2, 3x(HI 2, LO 2), LOAD 2, SETTLE 2
    req(2'd1, 1'b1, 8'd3, 1'b0, 19, t);
    chk("seq_phasesel", phasesel, 1);
    chk("seq_phasedir", phasedir, 1);
    ps = '0; lr = '0; bz = '0;
    for (int i = 0; i < 19; i++) begin
      ps = {ps[17:0], phasestep};
      lr = {lr[17:0], phaseloadreg};
      bz = {bz[17:0], busy};
      if (i < 18) @(negedge clk);
    end
    chk("seq_phasestep_pattern", ps, 19'b0011001100110000000);
    chk("seq_loadreg_pattern", lr, 19'b0000000000000011000);
    chk("seq_busy_pattern", bz, 19'b1111111111111111110);
    @(negedge clk);
    chk("seq_phasesel_hold", phasesel, 1);

    // zero steps: done next cycle, no pin activity
    req(2'd0, 1'b0, 8'd0, 1'b0, 1, t);
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      any |= phasestep | phaseloadreg | busy;
      @(negedge clk);
    end
    chk("zero_quiet", any, 0);
    chk("zero_phasesel_kept", phasesel, 1);
    chk("zero_phasedir_kept", phasedir, 1);

    // channel out of range with NCH=2
    req(2'd3, 1'b0, 8'd5, 1'b1, 1, t);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_phasesel_kept", phasesel, 1);
    chk("err_phasedir_kept", phasedir, 1);

    // lock loss in the middle of a 2-step sequence
    req(2'd0, 1'b0, 8'd2, 1'b0, 15, t);
    @(negedge clk);
    d = cyc;
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    chk("loss_rst_out_d2", rst_out, 0);
    @(negedge clk);
    chk("loss_rst_out_d3", rst_out, 1);
    chk("loss_count", lock_lost_cnt, 1);
    repeat (2) @(negedge clk);
    pll_locked = 1'b1;
    repeat (17) @(negedge clk);
    chk("relock_ready_d22", req_ready, 0);
    @(negedge clk);
    chk("relock_ready_d23", req_ready, 1);
    chk("relock_rst_out_d23", rst_out, 0);
    chk("relock_idle", busy, 0);

    // 1-cycle dropouts every 10 cycles never qualify
    seen_low = 1'b0;
    for (int rep = 0; rep < 12; rep++)
      for (int k = 0; k < 10; k++) begin
        pll_locked = (k != 9);
        @(negedge clk);
        if (rep >= 2 && !rst_out) seen_low = 1'b1;
      end
    pll_locked = 1'b1;
    chk("glitch_rst_out_never_low", seen_low, 0);
    chk("glitch_lost_count", lock_lost_cnt, 2);

    // 300 qualified losses saturate the counter
    for (int n = 0; n < 300; n++) begin
      repeat (20) @(negedge clk);
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      pll_locked = 1'b1;
    end
    chk("lost_saturated", lock_lost_cnt, 255);

    w = 0;
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("relock_wait", req_ready, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    // asynchronous reset during STEP_HI
    req(2'd1, 1'b0, 8'd3, 1'b0, 19, t);
    w = 0;
    while (!phasestep && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("arst_step_hi_seen", phasestep, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_phasestep", phasestep, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rst_out", rst_out, 1);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_phasesel", phasesel, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_resume", busy | phasestep | phaseloadreg, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
